setuphold_window_monitor: RTL and testbench
===========================================

SETUPHOLD_WINDOW_MONITOR -- requirements
Module: setuphold_window_monitor

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3, setup window in clk samples; 0 disables setup checking.
REQ-002 SHALL have parameter HOLD_CYC, default 2, hold window in clk samples; 0 disables hold checking.
REQ-003 SHALL have parameter CNT_W, default 8, width of the violation counters.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port mon_clk  input  1  monitored reference signal, sampled by clk.
REQ-007 SHALL have port mon_data  input  1  monitored data signal, sampled by clk.
REQ-008 SHALL have port clear  input  1  synchronous clear of both violation counters.
REQ-009 SHALL have port setup_viol  output  1  one-cycle setup violation pulse.
REQ-010 SHALL have port hold_viol  output  1  one-cycle hold violation pulse.
REQ-011 SHALL have port setup_cnt  output  CNT_W  saturating setup violation count.
REQ-012 SHALL have port hold_cnt  output  CNT_W  saturating hold violation count.
REQ-013 SHALL have port notifier  output  1  toggles once per clk cycle in which any violation is flagged.
REQ-014 SHALL have port in_hold  output  1  high while the hold window is open (state HOLD).

Function
REQ-015 SHALL register mon_clk and mon_data each clk edge (sample n) and compare against sample n-1; ref edge = 0->1 on mon_clk; data edge = any change on mon_data.
REQ-016 SHALL suppress edge detection for the first sample after rst deasserts (no prior sample valid).
REQ-017 SHALL flag a setup violation at ref edge sample m if the most recent data edge sample k satisfies 0 <= m-k < SETUP_CYC (coincident data edge counts as setup).
REQ-018 SHALL track data-edge age in a counter saturating at SETUP_CYC; after reset the age SHALL be saturated (no prior edge).
REQ-019 SHALL implement states IDLE and HOLD; ref edge with HOLD_CYC>0 -> HOLD with window counter loaded so the window covers samples m+1..m+HOLD_CYC.
REQ-020 SHALL flag a hold violation on a data edge at any sample inside the open window, then return to IDLE (at most one hold violation per window).
REQ-021 SHALL return HOLD -> IDLE when the window expires without a data edge.
REQ-022 SHALL, on a new ref edge while in HOLD, restart the window; a data edge on that same sample flags both hold_viol (old window) and setup_viol (new edge).
REQ-023 SHALL register setup_viol/hold_viol so they are high for exactly one clk cycle, two clk edges after the triggering input change is presented.
REQ-024 SHALL increment setup_cnt/hold_cnt by one per corresponding pulse, holding at all-ones without wrapping.
REQ-025 SHALL zero both counters on clear; clear coincident with a violation leaves counters at 0 but the pulse and notifier toggle still occur.
REQ-026 SHALL toggle notifier exactly once when setup_viol and hold_viol assert in the same cycle.
REQ-027 SHALL treat repeated data edges within the setup window as one age restart; only ref edges generate setup checks.

Reset
REQ-028 SHALL on rst: state IDLE, in_hold 0, both pulses 0, both counters 0, notifier 0, sample registers 0, age saturated, sample-valid flag cleared.
REQ-029 SHALL let rst override clear and all detection in the same cycle; rst mid-HOLD discards the open window without flagging.

Verification (SETUP_CYC=3, HOLD_CYC=2, CNT_W=8)
REQ-030 SHALL pass: data edge at sample 10, ref edge at 12 -> setup_viol pulse, setup_cnt=1, notifier=1; ref edge at 13 instead -> no violation.
REQ-031 SHALL pass: ref edge at 20, data edge at 22 -> hold_viol, hold_cnt=1; data edge at 23 -> none; second data edge at 21 and 22 -> only one hold_viol.
REQ-032 SHALL pass: data and ref edge coincident at sample 30 -> setup_viol only; ref edge at 40, ref+data edge at 41 -> both pulses same cycle, notifier toggles once.
REQ-033 SHALL pass: 300 setup violations -> setup_cnt holds 255; clear asserted with a violation -> setup_cnt=0, setup_viol=1.
REQ-034 SHALL pass: rst asserted during HOLD followed by data edge right after rst -> no pulses, in_hold=0, all counters 0; mon_data=1 at first post-reset sample -> no data edge detected.

Source files
------------

// File: rtl/setuphold_window_monitor.sv
// Setup/hold window monitor: samples a reference and a data signal on clk,
// flags setup and hold timing violations, and counts them.
module setuphold_window_monitor #(
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             mon_data,
    input  logic             clear,
    output logic             setup_viol,
    output logic             hold_viol,
    output logic [CNT_W-1:0] setup_cnt,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             notifier,
    output logic             in_hold
);

    localparam int AW = (SETUP_CYC < 1) ? 1 : $clog2(SETUP_CYC + 1);
    localparam int WW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(SETUP_CYC);
    localparam logic [WW-1:0] WIN_LD  = WW'(HOLD_CYC);

    typedef enum logic {IDLE, HOLD} state_t;

    logic          smp_clk, smp_data, prv_clk, prv_data;
    logic          smp_vld, prv_vld;
    logic [AW-1:0] age, cur_age;
    logic [WW-1:0] wcnt, wcnt_nxt;
    state_t        state, state_nxt;
    logic          edge_ok, ref_edge, data_edge;
    logic          setup_det, hold_det;

    // Two-deep sample history; edges are only trusted once both entries
    // hold real post-reset samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_clk  <= 1'b0;
            smp_data <= 1'b0;
            prv_clk  <= 1'b0;
            prv_data <= 1'b0;
            smp_vld  <= 1'b0;
            prv_vld  <= 1'b0;
        end else begin
            prv_clk  <= smp_clk;
            prv_data <= smp_data;
            smp_clk  <= mon_clk;
            smp_data <= mon_data;
            smp_vld  <= 1'b1;
            prv_vld  <= smp_vld;
        end
    end

    assign edge_ok   = smp_vld & prv_vld;
    assign ref_edge  = edge_ok & ~prv_clk & smp_clk;
    assign data_edge = edge_ok & (prv_data ^ smp_data);

    // Age of the latest data edge as of the current sample, saturating.
    always_comb begin
        cur_age = AGE_SAT;
        if (data_edge)
            cur_age = '0;
        else if (age < AGE_SAT)
            cur_age = age + AW'(1);
    end

    assign setup_det = (SETUP_CYC > 0) && ref_edge && (int'(cur_age) < SETUP_CYC);

    always_ff @(posedge clk) begin
        if (rst)
            age <= AGE_SAT;
        else
            age <= cur_age;
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        hold_det  = 1'b0;
        case (state)
            IDLE: begin
                if (ref_edge && (HOLD_CYC > 0)) begin
                    state_nxt = HOLD;
                    wcnt_nxt  = WIN_LD;
                end
            end
            HOLD: begin
                hold_det = data_edge;
                // A fresh ref edge reopens the window after the old one is judged.
                if (ref_edge) begin
                    state_nxt = HOLD;
                    wcnt_nxt  = WIN_LD;
                end else if (data_edge || (wcnt == WW'(1))) begin
                    state_nxt = IDLE;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt  = wcnt - WW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                wcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    assign in_hold = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            setup_viol <= 1'b0;
            hold_viol  <= 1'b0;
            notifier   <= 1'b0;
            setup_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            setup_viol <= setup_det;
            hold_viol  <= hold_det;
            notifier   <= notifier ^ (setup_det | hold_det);
            if (clear) begin
                setup_cnt <= '0;
                hold_cnt  <= '0;
            end else begin
                if (setup_det && (setup_cnt != '1))
                    setup_cnt <= setup_cnt + CNT_W'(1);
                if (hold_det && (hold_cnt != '1))
                    hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_setuphold_window_monitor.sv
// Scoreboard bench: a sample-history reference model predicts the outputs
// after every clk edge; a negedge monitor compares them.
module tb_setuphold_window_monitor;

    localparam int S = 3;
    localparam int H = 2;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, mon_clk, mon_data, clear;
    logic         setup_viol, hold_viol, notifier, in_hold;
    logic [W-1:0] setup_cnt, hold_cnt;

    setuphold_window_monitor #(.SETUP_CYC(S), .HOLD_CYC(H), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .mon_clk(mon_clk), .mon_data(mon_data),
        .clear(clear), .setup_viol(setup_viol), .hold_viol(hold_viol),
        .setup_cnt(setup_cnt), .hold_cnt(hold_cnt), .notifier(notifier),
        .in_hold(in_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sv, hv, nt, ih;
        int sc, hc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: every post-reset sample is kept in order, and the
    // rules are evaluated on sample indices.
    bit hist_c[$];
    bit hist_d[$];
    int last_de = -100;
    int win_hi  = 0;
    int win_lo  = 0;
    bit win_open = 0;
    int m_sc = 0, m_hc = 0;
    bit m_nt = 0;
    bit cur_c = 0, cur_d = 0;

    task automatic step(input bit r, input bit cl, input bit c, input bit d);
        exp_t e;
        int   j;
        bit   sv, hv, ih, re, de;
        rst = r; clear = cl; mon_clk = c; mon_data = d;
        cur_c = c; cur_d = d;
        sv = 0; hv = 0; ih = 0;
        if (r) begin
            hist_c.delete(); hist_d.delete();
            last_de = -100; win_open = 0;
            m_sc = 0; m_hc = 0; m_nt = 0;
        end else begin
            j = hist_c.size() - 1;
            if (j >= 1) begin
                re = !hist_c[j-1] && hist_c[j];
                de = hist_d[j] != hist_d[j-1];
                if (de) last_de = j;
                sv = re && (j - last_de < S);
                if (de && win_open && j >= win_lo && j <= win_hi) begin
                    hv = 1; win_open = 0;
                end
                if (re && H > 0) begin
                    win_open = 1; win_lo = j + 1; win_hi = j + H;
                end
                ih = win_open && (j < win_hi);
                if (!ih) win_open = 0;
            end
            if (cl) begin
                m_sc = 0; m_hc = 0;
            end else begin
                if (sv && m_sc < 255) m_sc++;
                if (hv && m_hc < 255) m_hc++;
            end
            if (sv || hv) m_nt = !m_nt;
            hist_c.push_back(c);
            hist_d.push_back(d);
        end
        e.sv = sv; e.hv = hv; e.ih = ih; e.nt = m_nt; e.sc = m_sc; e.hc = m_hc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit c, input bit d);
        step(0, 0, c, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(cur_c, cur_d);
    endtask

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("setup_viol", int'(setup_viol), int'(e.sv));
            chk("hold_viol",  int'(hold_viol),  int'(e.hv));
            chk("setup_cnt",  int'(setup_cnt),  e.sc);
            chk("hold_cnt",   int'(hold_cnt),   e.hc);
            chk("notifier",   int'(notifier),   int'(e.nt));
            chk("in_hold",    int'(in_hold),    int'(e.ih));
        end
    end

    initial begin
        bit d;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(5);
        // Data edge two samples before ref edge: setup violation.
        tick(0, 1); tick(0, 1); tick(1, 1); tick(0, 1); idle(4);
        // Data edge three samples before ref edge: clean.
        tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0); idle(4);
        // Data edge two samples after ref edge: hold violation.
        tick(1, 0); tick(1, 0); tick(1, 1); tick(0, 1); idle(4);
        // Three samples after: clean.
        tick(1, 1); tick(1, 1); tick(1, 1); tick(0, 0); idle(4);
        // Data edges on both window samples: one hold violation.
        tick(1, 0); tick(1, 1); tick(1, 0); tick(0, 0); idle(4);
        // Coincident ref and data edge: setup only.
        tick(1, 1); tick(0, 1); idle(4);
        // Ref edge, then ref+data edge inside the window: both pulses.
        tick(0, 1); tick(1, 1); tick(0, 1); tick(1, 0); tick(0, 0); idle(4);
        // Drive the setup counter into saturation.
        d = cur_d;
        for (int i = 0; i < 300; i++) begin
            d = !d; tick(0, d);
            tick(1, d);
        end
        idle(3);
        // Clear on the edge that registers a violation.
        tick(0, 1); tick(1, 0); step(0, 1, 0, 0); idle(4);
        // Reset in the middle of an open hold window, data edge right after.
        tick(0, 0); tick(1, 0);
        step(1, 0, 1, 0);
        tick(1, 1); tick(1, 1); tick(0, 1); idle(4);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit c2, d2, cl2, r2;
            c2  = ($urandom_range(0, 2) == 0) ? !cur_c : cur_c;
            d2  = ($urandom_range(0, 3) == 0) ? !cur_d : cur_d;
            cl2 = ($urandom_range(0, 49) == 0);
            r2  = ($urandom_range(0, 299) == 0);
            step(r2, cl2, c2, d2);
        end
        idle(2);
        #10;
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
